// File: rtl/coder_pkg.sv
// Shared constants and the reference parity function for the link coder family.
package coder_pkg;

    localparam int MODE_PAR = 0;
    localparam int MODE_SER = 1;

    // Row i (bits i*12 +: 12) is the parity contribution of data bit i.
    localparam logic [143:0] GOLAY_B =
        144'hFFE_6E3_B71_5B9_2DD_16F_8B7_C5B_E2D_717_B8B_DC5;

    localparam int PC_MAX_K = 32;
    localparam int PC_MAX_R = 32;

    function automatic logic [PC_MAX_R-1:0] parity_calc(
        input logic [PC_MAX_K-1:0]          data,
        input logic [PC_MAX_K*PC_MAX_R-1:0] pmat,
        input int                           k,
        input int                           r
    );
        logic [PC_MAX_R-1:0] p;
        p = '0;
        for (int i = 0; i < PC_MAX_K; i++) begin
            for (int j = 0; j < PC_MAX_R; j++) begin
                if (i < k && j < r)
                    p[j] = p[j] ^ (data[i] & pmat[i*r + j]);
            end
        end
        return p;
    endfunction

endpackage

// File: rtl/coder_stream_parity_gen.sv
// Combinational parity generator: each parity bit is the XOR of the data bits
// selected by one column of the parity matrix.
module parity_gen #(
    parameter int               K    = 12,
    parameter int               R    = 12,
    parameter logic [K*R-1:0]   PMAT = coder_pkg::GOLAY_B
) (
    input  logic [K-1:0] data_i,
    output logic [R-1:0] parity_o
);

    for (genvar j = 0; j < R; j++) begin : g_col
        logic [K-1:0] col;
        for (genvar i = 0; i < K; i++) begin : g_row
            assign col[i] = PMAT[i*R + j];
        end
        assign parity_o[j] = ^(data_i & col);
    end

endmodule

// File: rtl/coder_stream.sv
// Handshaked systematic block encoder: {data, parity} codewords emitted either
// one per handshake (parallel) or MSB-first as a bit stream (serial).
module coder_stream
    import coder_pkg::*;
#(
    parameter int             K     = 12,
    parameter int             R     = 12,
    parameter logic [K*R-1:0] PMAT  = GOLAY_B,
    parameter int             MODE  = MODE_PAR,
    parameter int             CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             enable,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [K-1:0]     in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [K+R-1:0]   out_data,
    output logic             out_bit,
    output logic             out_first,
    output logic             out_last,
    output logic [CNT_W-1:0] word_cnt
);

    localparam int N = K + R;

    logic [R-1:0]     parity;
    logic [N-1:0]     cw;
    logic             accept;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    parity_gen #(.K(K), .R(R), .PMAT(PMAT)) u_parity (
        .data_i   (in_data),
        .parity_o (parity)
    );

    assign cw     = {in_data, parity};
    assign accept = in_valid & in_ready;

    always_comb begin
        cnt_d = cnt_q;
        if (accept) cnt_d = cnt_q + CNT_W'(1);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) cnt_q <= '0;
        else        cnt_q <= cnt_d;
    end

    assign word_cnt = cnt_q;

    if (MODE == MODE_PAR) begin : g_par
        logic         vld_q, vld_d;
        logic [N-1:0] data_q, data_d;

        assign in_ready = enable & (!vld_q | out_ready);

        always_comb begin
            vld_d  = vld_q;
            data_d = data_q;
            if (accept) begin
                vld_d  = 1'b1;
                data_d = cw;
            end else if (enable & vld_q & out_ready) begin
                vld_d  = 1'b0;
            end
        end

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                vld_q  <= 1'b0;
                data_q <= '0;
            end else begin
                vld_q  <= vld_d;
                data_q <= data_d;
            end
        end

        assign out_valid = vld_q & enable;
        assign out_data  = data_q;
        assign out_bit   = 1'b0;
        assign out_first = 1'b0;
        assign out_last  = 1'b0;
    end else if (MODE == MODE_SER) begin : g_ser
        localparam int IDX_W = $clog2(N);

        logic [N-1:0]     shift_q, shift_d;
        logic [N-1:0]     data_q, data_d;
        logic [IDX_W-1:0] idx_q, idx_d;
        logic             busy_q, busy_d;
        logic             last, step;

        assign last     = busy_q & (idx_q == IDX_W'(N-1));
        assign step     = enable & busy_q & out_ready;
        // A new word may load on the final-bit handshake, so frames abut.
        assign in_ready = enable & (!busy_q | (last & out_ready));

        always_comb begin
            shift_d = shift_q;
            data_d  = data_q;
            idx_d   = idx_q;
            busy_d  = busy_q;
            if (accept) begin
                shift_d = cw;
                data_d  = cw;
                idx_d   = '0;
                busy_d  = 1'b1;
            end else if (step) begin
                shift_d = {shift_q[N-2:0], 1'b0};
                if (last) begin
                    idx_d  = '0;
                    busy_d = 1'b0;
                end else begin
                    idx_d  = idx_q + IDX_W'(1);
                end
            end
        end

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                shift_q <= '0;
                data_q  <= '0;
                idx_q   <= '0;
                busy_q  <= 1'b0;
            end else begin
                shift_q <= shift_d;
                data_q  <= data_d;
                idx_q   <= idx_d;
                busy_q  <= busy_d;
            end
        end

        assign out_valid = busy_q & enable;
        assign out_data  = data_q;
        assign out_bit   = shift_q[N-1];
        assign out_first = busy_q & (idx_q == '0);
        assign out_last  = last;
    end else begin : g_bad
        $error("coder_stream: MODE must be 0 (parallel) or 1 (serial)");
    end

endmodule

// File: tb/tb_coder_stream.sv
// Directed bench: one parallel and one serial instance sharing clock and reset.
module tb_coder_stream;

    logic        clk = 1'b0;
    logic        rst_n;

    logic        en0, iv0, ir0, ov0, ordy0, ob0, of0, ol0;
    logic [11:0] id0;
    logic [23:0] od0;
    logic [15:0] wc0;

    logic        en1, iv1, ir1, ov1, ordy1, ob1, of1, ol1;
    logic [11:0] id1;
    logic [23:0] od1;
    logic [15:0] wc1;

    logic [23:0] cw;
    int          n_chk = 0;
    int          n_err = 0;

    always #5 clk = ~clk;

    coder_stream #(.MODE(0)) u_par (
        .clk(clk), .rst_n(rst_n), .enable(en0),
        .in_valid(iv0), .in_ready(ir0), .in_data(id0),
        .out_valid(ov0), .out_ready(ordy0), .out_data(od0),
        .out_bit(ob0), .out_first(of0), .out_last(ol0), .word_cnt(wc0)
    );

    coder_stream #(.MODE(1)) u_ser (
        .clk(clk), .rst_n(rst_n), .enable(en1),
        .in_valid(iv1), .in_ready(ir1), .in_data(id1),
        .out_valid(ov1), .out_ready(ordy1), .out_data(od1),
        .out_bit(ob1), .out_first(of1), .out_last(ol1), .word_cnt(wc1)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset;
        tick;
        rst_n = 1'b0;
        tick;
        rst_n = 1'b1;
    endtask

    initial begin
        rst_n = 1'b0;
        {en0, iv0, ordy0, en1, iv1, ordy1} = '0;
        id0 = '0;
        id1 = '0;
        cw  = '0;
        #12;
        chk("rst ov0", ov0, 0);
        chk("rst od0", od0, 0);
        chk("rst wc0", wc0, 0);
        chk("rst ov1", ov1, 0);
        chk("rst ob1", ob1, 0);
        chk("rst of1", of1, 0);
        chk("rst ol1", ol1, 0);
        chk("rst od1", od1, 0);
        rst_n = 1'b1;
        tick;

        // parallel: single word, latency 1
        en0 = 1; iv0 = 1; id0 = 12'h0F0; ordy0 = 0;
        #1 chk("t1 ir0", ir0, 1);
        tick;
        iv0 = 0;
        #1;
        chk("t1 ov0", ov0, 1);
        chk("t1 od0", od0, 24'h0F075E);
        chk("t1 wc0", wc0, 1);

        // parallel: back-to-back words with no bubble
        do_reset;
        en0 = 1; ordy0 = 1; iv0 = 1; id0 = 12'h001;
        tick;
        chk("t2 od0 a", od0, 24'h001DC5);
        chk("t2 ov0 a", ov0, 1);
        id0 = 12'h800;
        tick;
        chk("t2 od0 b", od0, 24'h800FFE);
        chk("t2 ov0 b", ov0, 1);
        id0 = 12'h0F1;
        tick;
        chk("t2 od0 c", od0, 24'h0F1A9B);
        chk("t2 wc0", wc0, 3);
        iv0 = 0;
        tick;
        chk("t2 drain ov0", ov0, 0);
        chk("t2 hold od0", od0, 24'h0F1A9B);

        // parallel: backpressure stalls the register
        ordy0 = 0; iv0 = 1; id0 = 12'h0F0;
        tick;
        id0 = 12'h001;
        for (int c = 0; c < 10; c++) begin
            #1;
            chk("t3 ir0 stall", ir0, 0);
            chk("t3 od0 stall", od0, 24'h0F075E);
            chk("t3 ov0 stall", ov0, 1);
            tick;
        end
        ordy0 = 1;
        #1 chk("t3 ir0 go", ir0, 1);
        tick;
        chk("t3 od0 next", od0, 24'h001DC5);
        chk("t3 wc0", wc0, 5);
        iv0 = 0;
        tick;
        en0 = 0;

        // serial: 001 with 800 queued behind it
        en1 = 1; ordy1 = 1; iv1 = 1; id1 = 12'h001;
        #1 chk("t4 ir1 idle", ir1, 1);
        tick;
        id1 = 12'h800;
        cw  = 24'h001DC5;
        for (int b = 0; b < 24; b++) begin
            chk("t4 ov1", ov1, 1);
            chk("t4 ob1", ob1, cw[23-b]);
            chk("t4 of1", of1, b == 0);
            chk("t4 ol1", ol1, b == 23);
            chk("t4 ir1", ir1, b == 23);
            tick;
        end
        iv1 = 0;
        cw  = 24'h800FFE;
        #1;
        chk("t4 next of1", of1, 1);
        chk("t4 next ob1", ob1, 1);
        chk("t4 next od1", od1, 24'h800FFE);
        chk("t4 wc1", wc1, 2);

        // serial: enable low while bit 7 is presented
        for (int b = 0; b < 6; b++) begin
            chk("t5 ob1 pre", ob1, cw[23-b]);
            tick;
        end
        en1 = 0;
        #1;
        for (int c = 0; c < 5; c++) begin
            chk("t5 ov1 frz", ov1, 0);
            chk("t5 ir1 frz", ir1, 0);
            chk("t5 ob1 frz", ob1, cw[17]);
            tick;
        end
        en1 = 1;
        #1;
        for (int b = 6; b < 24; b++) begin
            chk("t5 ov1", ov1, 1);
            chk("t5 ob1", ob1, cw[23-b]);
            chk("t5 ol1", ol1, b == 23);
            tick;
        end
        chk("t5 done ov1", ov1, 0);
        chk("t5 wc1", wc1, 2);

        // serial: reset mid-frame at bit 12
        iv1 = 1; id1 = 12'h0F1;
        tick;
        iv1 = 0;
        cw  = 24'h0F1A9B;
        for (int b = 0; b < 11; b++) tick;
        chk("t6 ob1 b12", ob1, cw[12]);
        rst_n = 1'b0;
        #1;
        chk("t6 ov1", ov1, 0);
        chk("t6 ob1", ob1, 0);
        chk("t6 of1", of1, 0);
        chk("t6 ol1", ol1, 0);
        chk("t6 od1", od1, 0);
        chk("t6 wc1", wc1, 0);
        tick;
        rst_n = 1'b1;
        iv1 = 1; id1 = 12'h001;
        tick;
        iv1 = 0;
        cw  = 24'h001DC5;
        for (int b = 0; b < 24; b++) begin
            chk("t6 ov1 new", ov1, 1);
            chk("t6 ob1 new", ob1, cw[23-b]);
            chk("t6 of1 new", of1, b == 0);
            tick;
        end
        chk("t6 wc1 new", wc1, 1);
        chk("t6 end ov1", ov1, 0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule

// File: doc/coder_stream.md
Name: coder_stream

Overview:
Parametrised, handshaked systematic block encoder for the noise-tolerant link. It is the successor to the combinational 12→24 coder. It accepts K-bit data words over valid/ready and emits N=K+R-bit codewords {data, parity}, where the parity comes from a parameterised K×R parity matrix (default: extended Golay (24,12) B matrix). Output is either one parallel codeword per handshake (MODE=0) or a bit-serial stream (MODE=1) feeding the channel modulator.

Parameters:
K, 12, data word width (≥1)
R, 12, parity width (≥1)
PMAT, coder_pkg::GOLAY_B, K*R-bit parity matrix; row i at PMAT[i*R +: R] is XORed into parity when in_data[i]=1
MODE, 0, 0 = parallel codeword output, 1 = serial MSB-first output; any other value is an elaboration error
CNT_W, 16, width of the accepted-word counter

Ports:
clk  in  1  clock, all state on rising edge
rst_n  in  1  asynchronous active-low reset
enable  in  1  global run enable; low freezes all state
in_valid  in  1  input word valid
in_ready  out  1  block can accept a word this cycle
in_data  in  K  data word
out_valid  out  1  output valid (codeword in MODE 0, bit in MODE 1)
out_ready  in  1  downstream accepts
out_data  out  N  codeword; in MODE 1 holds the codeword being serialised
out_bit  out  1  MODE 1 serial bit; 0 in MODE 0
out_first  out  1  MODE 1: bit is codeword bit N-1 (first bit); 0 in MODE 0
out_last  out  1  MODE 1: bit is codeword bit 0 (last bit); 0 in MODE 0
word_cnt  out  CNT_W  number of accepted input words, mod 2^CNT_W

Behaviour:
- Reset (async, rst_n=0): out_valid=0, out_data=0, out_bit/out_first/out_last=0, word_cnt=0, bit index=0, busy=0. Effect is immediate, including mid-codeword; the partial codeword is discarded.
- Encode: parity[j] = XOR over i of (in_data[i] & PMAT[i*R+j]). Codeword = {in_data, parity}: data occupies bits N-1..R.
- Accept = in_valid & in_ready. in_ready is 0 whenever enable=0.
- Each accept increments word_cnt, wrapping from 2^CNT_W-1 to 0.
- enable=0: no state changes; out_valid is masked to 0 and other outputs hold. Resumes exactly where it stopped.
- MODE 0 (single output register, latency 1):
  - in_ready = enable & (!out_valid_int | out_ready).
  - On accept, out_data loads the codeword and out_valid=1 in the next cycle.
  - Output consumed with no accept in the same cycle: out_valid→0 and out_data holds.
  - Consume and accept in the same cycle: the new codeword loads, giving full throughput of 1 word/cycle.
- MODE 1 (shift register + bit index 0..N-1):
  - out_bit = current MSB of the shift register; out_first = (idx==0); out_last = (idx==N-1); out_valid = busy & enable.
  - Each out_valid & out_ready advances idx and shifts left.
  - in_ready = enable & (!busy | (out_last & out_ready)).
  - Accept on the last-bit handshake: the new codeword loads and idx=0 next cycle, with no bubble.
  - Last bit consumed with no accept: busy→0.
- Holding out_ready=0 freezes the current bit or codeword indefinitely.

Decomposition:
- coder_pkg holds:
  - GOLAY_B, 144 bits; rows 0..11 (row i = parity contribution of d[i], row bit R-1 = parity MSB): DC5, B8B, 717, E2D, C5B, 8B7, 16F, 2DD, 5B9, B71, 6E3, FFE.
  - Mode localparams MODE_PAR=0, MODE_SER=1.
  - Function parity_calc(data, pmat).
- One combinational sub-module, parity_gen (K, R, PMAT → parity), reused by the future decoder's syndrome path.
- The handshake/serialiser stays in coder_stream, with a generate on MODE.

Test Plan:
1. MODE 0, reset, then accept 12'h0F0 → next cycle out_valid=1, out_data=24'h0F075E, word_cnt=1.
2. MODE 0, out_ready=1, back-to-back 12'h001, 12'h800, 12'h0F1 → consecutive cycles 24'h001DC5, 24'h800FFE, 24'h0F1A9B with no bubble; word_cnt=3.
3. MODE 0, out_ready=0 with out_valid=1 → in_ready=0, out_data stable 10 cycles; out_ready=1 → drains, accepts next word.
4. MODE 1, 12'h001 then queued 12'h800 → 24 bits 0000_0000_0001_1101_1100_0101 MSB first. out_first on bit 1, out_last on bit 24. The 25th cycle carries the first bit of 24'h800FFE (bit 1).
5. MODE 1, enable=0 at bit 7 for 5 cycles → out_valid=0, idx frozen; on resume, bit 7 is re-presented and the stream completes correctly.
6. rst_n=0 mid-serial frame (bit 12) → all outputs 0 the same cycle, word_cnt=0. After release, a new word encodes from bit 1.
